// File: rtl/core_pkg.sv
// Shared definitions for the core load/store path: access-width codes,
// LSU state encoding and the byte-enable helper used by the store side.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } lsu_state_t;

    // funct3[1:0] picks the width; codes 3, 6 and 7 fall through to word
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            F3_B[1:0]: be = 4'b0001 << off;
            F3_H[1:0]: be = 4'b0011 << {off[1], 1'b0};
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Lane steering for the LSU: store be/wdata/misalign and load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
module core_lsu_align
    import core_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        st_misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_be = byte_en(st_funct3, st_off);
        case (st_funct3[1:0])
            F3_B[1:0]: begin
                st_wdata    = {4{st_data[7:0]}};
                st_misalign = 1'b0;
            end
            F3_H[1:0]: begin
                st_wdata    = {2{st_data[15:0]}};
                st_misalign = st_off[0];
            end
            default: begin
                st_wdata    = st_data;
                st_misalign = |st_off;
            end
        endcase
    end

    always_comb begin
        shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// M-stage load/store unit: issues dmem transactions, stalls until they complete.
// Latency: store 1 cycle with same-cycle gnt; load minimum 3 cycles (issue, rvalid, RESP).
// Backpressure: lsu_stall holds M while waiting on dmem_gnt/dmem_rvalid or a drain.
module core_lsu
    import core_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BUS_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic              m_mem_ren,
    input  logic              m_mem_wen,
    input  logic [2:0]        m_funct3,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_store_data,
    input  logic              m_flush,
    output logic              lsu_stall,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_misalign,
    output logic              bus_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    lsu_state_t state, state_nxt;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_inc, rdata_ld, load_issue, timeout, op;
    logic [3:0]       be;
    logic [31:0]      wdata, ld_data;
    logic             misalign;

    core_lsu_align u_align (
        .st_funct3   (m_funct3),
        .st_off      (m_addr[1:0]),
        .st_data     (m_store_data),
        .st_be       (be),
        .st_wdata    (wdata),
        .st_misalign (misalign),
        .ld_funct3   (f3_q),
        .ld_off      (off_q),
        .ld_rdata    (dmem_rdata),
        .ld_data     (ld_data)
    );

    assign op      = m_valid & (m_mem_ren | m_mem_wen) & ~m_flush;
    assign timeout = (BUS_TIMEOUT > 0) && (cnt == CNT_W'(BUS_TIMEOUT - 1));

    always_comb begin
        state_nxt    = state;
        lsu_stall    = 1'b0;
        lsu_done     = 1'b0;
        lsu_misalign = 1'b0;
        bus_err      = 1'b0;
        dmem_req     = 1'b0;
        cnt_inc      = 1'b0;
        rdata_ld     = 1'b0;
        load_issue   = 1'b0;
        case (state)
            IDLE: begin
                if (op && misalign) begin
                    lsu_misalign = 1'b1;
                    lsu_done     = 1'b1;
                end else if (op) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt && m_mem_wen) begin
                        lsu_done = 1'b1;
                    end else if (dmem_gnt) begin
                        lsu_stall  = 1'b1;
                        load_issue = 1'b1;
                        state_nxt  = RWAIT;
                    end else if (timeout) begin
                        bus_err  = 1'b1;
                        lsu_done = 1'b1;
                    end else begin
                        lsu_stall = 1'b1;
                        cnt_inc   = 1'b1;
                    end
                end
            end
            RWAIT: begin
                lsu_stall = ~m_flush;
                if (dmem_rvalid) begin
                    rdata_ld  = ~m_flush;
                    state_nxt = m_flush ? IDLE : RESP;
                end else if (m_flush) begin
                    state_nxt = DRAIN;
                end else if (timeout) begin
                    lsu_stall = 1'b0;
                    bus_err   = 1'b1;
                    lsu_done  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                lsu_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                // the flushed read is still outstanding; a new op waits behind it
                lsu_stall = op;
                if (dmem_rvalid || timeout) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        endcase
    end

    assign dmem_we    = dmem_req & m_mem_wen;
    assign dmem_addr  = dmem_req ? {m_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? be : 4'b0000;
    assign dmem_wdata = dmem_req ? wdata : 32'd0;
    assign lsu_rdata  = (state == RESP) ? rdata_q : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_inc ? cnt + 1'b1 : '0;
            if (load_issue) begin
                off_q <= m_addr[1:0];
                f3_q  <= m_funct3;
            end
            if (rdata_ld) begin
                rdata_q <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu; the testbench drives the dmem handshake cycle by cycle.
// Inputs change 1ns after posedge, outputs are checked at the following negedge.
module tb_core_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid, m_mem_ren, m_mem_wen, m_flush;
    logic [2:0]  m_funct3;
    logic [31:0] m_addr, m_store_data;
    logic        lsu_stall, lsu_done, lsu_misalign, bus_err;
    logic [31:0] lsu_rdata;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_lsu #(.ADDR_W(32), .BUS_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_valid      (m_valid),
        .m_mem_ren    (m_mem_ren),
        .m_mem_wen    (m_mem_wen),
        .m_funct3     (m_funct3),
        .m_addr       (m_addr),
        .m_store_data (m_store_data),
        .m_flush      (m_flush),
        .lsu_stall    (lsu_stall),
        .lsu_rdata    (lsu_rdata),
        .lsu_done     (lsu_done),
        .lsu_misalign (lsu_misalign),
        .bus_err      (bus_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid = 0; m_mem_ren = 0; m_mem_wen = 0; m_flush = 0;
        m_funct3 = 3'd0; m_addr = 32'd0; m_store_data = 32'd0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 32'd0;
    endtask

    task automatic present(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd);
        m_valid = 1; m_mem_ren = ~wen; m_mem_wen = wen; m_flush = 0;
        m_funct3 = f3; m_addr = addr; m_store_data = sd;
    endtask

    // load granted at once, rvalid on the next cycle, result in RESP
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [3:0] exp_be,
                           input logic [31:0] exp);
        present(1'b0, f3, addr, 32'd0);
        dmem_gnt = 1;
        #4;
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be});
        check({tag, "_stall0"}, {31'd0, lsu_stall}, 32'd1);
        tick();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = rd;
        #4;
        check({tag, "_stall1"}, {31'd0, lsu_stall}, 32'd1);
        check({tag, "_done1"}, {31'd0, lsu_done}, 32'd0);
        tick();
        dmem_rvalid = 0; dmem_rdata = 32'd0;
        #4;
        check({tag, "_stall2"}, {31'd0, lsu_stall}, 32'd0);
        check({tag, "_done2"}, {31'd0, lsu_done}, 32'd1);
        check({tag, "_rdata"}, lsu_rdata, exp);
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        #4;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_stall", {31'd0, lsu_stall}, 32'd0);
        check("rst_done", {31'd0, lsu_done}, 32'd0);
        check("rst_rdata", lsu_rdata, 32'd0);
        tick();
        rst = 0;

        // SW 0x100, granted the same cycle
        present(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        dmem_gnt = 1;
        #4;
        check("sw_req", {31'd0, dmem_req}, 32'd1);
        check("sw_we", {31'd0, dmem_we}, 32'd1);
        check("sw_be", {28'd0, dmem_be}, 32'hF);
        check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        check("sw_addr", dmem_addr, 32'h100);
        check("sw_done", {31'd0, lsu_done}, 32'd1);
        check("sw_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();

        // SB 0x103, gnt arrives on the third request cycle
        present(1'b1, 3'd0, 32'h103, 32'h000000A5);
        for (int i = 0; i < 3; i++) begin
            dmem_gnt = (i == 2);
            #4;
            check("sb_req", {31'd0, dmem_req}, 32'd1);
            check("sb_be", {28'd0, dmem_be}, 32'h8);
            check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
            check("sb_addr", dmem_addr, 32'h100);
            check("sb_stall", {31'd0, lsu_stall}, (i == 2) ? 32'd0 : 32'd1);
            check("sb_done", {31'd0, lsu_done}, (i == 2) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();

        do_load("lb", 3'd0, 32'h102, 32'h1280FF00, 4'b0100, 32'hFFFFFF80);
        do_load("lbu", 3'd4, 32'h102, 32'h1280FF00, 4'b0100, 32'h00000080);
        do_load("lh", 3'd1, 32'h102, 32'h8280FF00, 4'b1100, 32'hFFFF8280);
        do_load("lhu", 3'd5, 32'h102, 32'h8280FF00, 4'b1100, 32'h00008280);
        do_load("lw", 3'd2, 32'h104, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

        // misaligned LH: retires at once with no bus request
        present(1'b0, 3'd1, 32'h101, 32'd0);
        #4;
        check("mis_flag", {31'd0, lsu_misalign}, 32'd1);
        check("mis_req", {31'd0, dmem_req}, 32'd0);
        check("mis_done", {31'd0, lsu_done}, 32'd1);
        check("mis_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();

        // LW flushed before gnt: request drops, nothing retires
        present(1'b0, 3'd2, 32'h104, 32'd0);
        #4;
        check("fl_req0", {31'd0, dmem_req}, 32'd1);
        check("fl_stall0", {31'd0, lsu_stall}, 32'd1);
        tick();
        m_flush = 1;
        #4;
        check("fl_req1", {31'd0, dmem_req}, 32'd0);
        check("fl_done1", {31'd0, lsu_done}, 32'd0);
        check("fl_stall1", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();

        // LW granted, flushed in RWAIT, rvalid 4 cycles after flush; SW waits
        present(1'b0, 3'd2, 32'h108, 32'd0);
        dmem_gnt = 1;
        #4;
        check("dr_stall0", {31'd0, lsu_stall}, 32'd1);
        tick();
        dmem_gnt = 0; m_flush = 1;
        #4;
        check("dr_stall_fl", {31'd0, lsu_stall}, 32'd0);
        check("dr_done_fl", {31'd0, lsu_done}, 32'd0);
        tick();
        present(1'b1, 3'd2, 32'h10C, 32'h11223344);
        for (int i = 1; i <= 4; i++) begin
            dmem_rvalid = (i == 4);
            dmem_rdata  = (i == 4) ? 32'hCAFEF00D : 32'd0;
            #4;
            check("dr_hold_stall", {31'd0, lsu_stall}, 32'd1);
            check("dr_hold_req", {31'd0, dmem_req}, 32'd0);
            check("dr_hold_done", {31'd0, lsu_done}, 32'd0);
            tick();
        end
        dmem_rvalid = 0; dmem_gnt = 1;
        #4;
        check("dr_sw_req", {31'd0, dmem_req}, 32'd1);
        check("dr_sw_wdata", dmem_wdata, 32'h11223344);
        check("dr_sw_addr", dmem_addr, 32'h10C);
        check("dr_sw_done", {31'd0, lsu_done}, 32'd1);
        check("dr_sw_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();

        // LW granted, rvalid never comes: bus_err on the 8th wait cycle
        present(1'b0, 3'd2, 32'h200, 32'd0);
        dmem_gnt = 1;
        #4;
        check("to_issue_stall", {31'd0, lsu_stall}, 32'd1);
        tick();
        dmem_gnt = 0;
        for (int i = 1; i <= 8; i++) begin
            #4;
            check("to_err", {31'd0, bus_err}, (i == 8) ? 32'd1 : 32'd0);
            check("to_done", {31'd0, lsu_done}, (i == 8) ? 32'd1 : 32'd0);
            check("to_stall", {31'd0, lsu_stall}, (i == 8) ? 32'd0 : 32'd1);
            if (i == 8) check("to_rdata", lsu_rdata, 32'd0);
            tick();
        end
        idle_inputs();
        dmem_rvalid = 1; dmem_rdata = 32'h12345678;
        #4;
        check("to_late_done", {31'd0, lsu_done}, 32'd0);
        check("to_late_err", {31'd0, bus_err}, 32'd0);
        check("to_late_stall", {31'd0, lsu_stall}, 32'd0);
        tick();
        idle_inputs();
        present(1'b1, 3'd0, 32'h201, 32'h0000003C);
        dmem_gnt = 1;
        #4;
        check("to_after_req", {31'd0, dmem_req}, 32'd1);
        check("to_after_be", {28'd0, dmem_be}, 32'h2);
        check("to_after_wdata", dmem_wdata, 32'h3C3C3C3C);
        check("to_after_done", {31'd0, lsu_done}, 32'd1);
        tick();
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
